// File: rtl/bpsk_tx_scheduler.sv
// Round-robin transmit scheduler for the BPSK modulator: accepts one word from two
// sources, strobes it into the modulator, then waits out the on-air time plus a guard gap.
module bpsk_tx_scheduler #(
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned BIT_PERIOD = 4,
   parameter int unsigned GAP_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              req0_valid,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   output logic              mod_ld,
   output logic [DATA_W-1:0] mod_data,
   output logic              active,
   output logic              grant,
   output logic              word_done
);

   localparam int unsigned BEATS = DATA_W * BIT_PERIOD;
   localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StLoad = 2'd1;
   localparam logic [1:0] StSend = 2'd2;
   localparam logic [1:0] StGap  = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [GAP_W-1:0]  gap_q, gap_d;
   logic              prio_q, prio_d;
   logic              grant_q, grant_d;
   logic [DATA_W-1:0] mod_data_q, mod_data_d;

   logic sel;
   logic can_accept;
   logic accept;

   // Channel 1 wins when it is the only requester or when both request and it holds priority.
   always_comb begin
      sel        = req1_valid & (~req0_valid | prio_q);
      can_accept = rst & en & (state_q == StIdle);
      req0_ready = can_accept & req0_valid & ~sel;
      req1_ready = can_accept & req1_valid & sel;
      accept     = req0_ready | req1_ready;
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      gap_d      = gap_q;
      prio_d     = prio_q;
      grant_d    = grant_q;
      mod_data_d = mod_data_q;
      case (state_q)
         StIdle: begin
            if (accept) begin
               mod_data_d = sel ? req1_data : req0_data;
               grant_d    = sel;
               prio_d     = ~sel;
               state_d    = StLoad;
            end
         end
         StLoad: begin
            cnt_d   = '0;
            state_d = StSend;
         end
         StSend: begin
            if (cnt_q == CNT_LAST) begin
               gap_d   = '0;
               state_d = (GAP_CYCLES > 0) ? StGap : StIdle;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StGap: begin
            if (gap_q == GAP_LAST) begin
               state_d = StIdle;
            end else begin
               gap_d = gap_q + GAP_W'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         gap_q      <= '0;
         prio_q     <= 1'b0;
         grant_q    <= 1'b0;
         mod_data_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         gap_q      <= gap_d;
         prio_q     <= prio_d;
         grant_q    <= grant_d;
         mod_data_q <= mod_data_d;
      end
   end

   always_comb begin
      mod_ld    = (state_q == StLoad);
      word_done = (state_q == StSend) && (cnt_q == CNT_LAST);
      active    = (state_q != StIdle);
      grant     = grant_q;
      mod_data  = mod_data_q;
   end

endmodule

// File: tb/tb_bpsk_tx_scheduler.sv
// Scoreboard bench for bpsk_tx_scheduler: expected loads are queued as words are offered
// and retired by a negedge monitor on each mod_ld; a second instance covers the short corner.
module tb_bpsk_tx_scheduler;

   localparam int BEATS  = 64;
   localparam int PERIOD = 68;

   typedef struct {
      logic [15:0] data;
      logic        grant;
      int          spacing;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic [15:0] req0_data = '0, req1_data = '0;
   logic        req0_ready, req1_ready, mod_ld, active, grant, word_done;
   logic [15:0] mod_data;

   logic        b_en = 1'b1, b_v0 = 1'b0, b_v1 = 1'b0;
   logic [15:0] b_d0 = '0, b_d1 = '0;
   logic        b_r0, b_r1, b_ld, b_active, b_grant, b_wd;
   logic [15:0] b_mdata;

   bpsk_tx_scheduler #(.DATA_W(16), .BIT_PERIOD(4), .GAP_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .en(en),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
      .mod_ld(mod_ld), .mod_data(mod_data), .active(active), .grant(grant),
      .word_done(word_done)
   );

   bpsk_tx_scheduler #(.DATA_W(16), .BIT_PERIOD(1), .GAP_CYCLES(0)) dut_short (
      .clk(clk), .rst(rst), .en(b_en),
      .req0_valid(b_v0), .req0_data(b_d0), .req0_ready(b_r0),
      .req1_valid(b_v1), .req1_data(b_d1), .req1_ready(b_r1),
      .mod_ld(b_ld), .mod_data(b_mdata), .active(b_active), .grant(b_grant),
      .word_done(b_wd)
   );

   always #5 clk = ~clk;

   int   n_tests = 0, n_fail = 0;
   int   cyc = 0;
   exp_t sb[$];
   exp_t mon_e;
   int   ld_count = 0, wd_count = 0, last_ld = -1000;
   logic prev_acc = 1'b0, prev_rst = 1'b0;
   logic [15:0] prev_md = '0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [15:0] d, input logic g, input int sp);
      exp_t e;
      e.data = d;
      e.grant = g;
      e.spacing = sp;
      sb.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_ld(input int target, input int budget, input string tag);
      int k = 0;
      while (ld_count < target && k < budget) begin
         @(negedge clk);
         #1;
         k++;
      end
      check_eq(tag, ld_count >= target, 1);
   endtask

   task automatic wait_wd(input int target, input int budget, input string tag);
      int k = 0;
      while (wd_count < target && k < budget) begin
         @(negedge clk);
         #1;
         k++;
      end
      check_eq(tag, wd_count >= target, 1);
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int k = 0;
      while (active && k < budget) begin
         @(negedge clk);
         #1;
         k++;
      end
      check_eq(tag, active, 0);
   endtask

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (mod_ld) begin
         ld_count++;
         if (sb.size() == 0) begin
            check_eq("sb_nonempty", sb.size(), 1);
         end else begin
            mon_e = sb.pop_front();
            check_eq("ld_data", mod_data, mon_e.data);
            check_eq("ld_grant", grant, mon_e.grant);
            if (mon_e.spacing != 0) check_eq("ld_spacing", cyc - last_ld, mon_e.spacing);
         end
         last_ld = cyc;
      end
      if (word_done) begin
         wd_count++;
         check_eq("wd_latency", cyc - last_ld, BEATS);
      end
      if (rst && !en) check_eq("ready_while_en_low", {req0_ready, req1_ready}, 0);
      if (rst && prev_rst && mod_data !== prev_md) check_eq("md_change_after_accept", prev_acc, 1);
      prev_acc = (req0_ready & req0_valid) | (req1_ready & req1_valid);
      prev_md  = mod_data;
      prev_rst = rst;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
      $fatal(1);
   end

   initial begin
      int base, wd0, ld0, t_prev, t_ld, k;

      // Reset, then a single word on channel 0
      #2 rst = 1'b0;
      #1;
      check_eq("rst_mod_ld", mod_ld, 0);
      check_eq("rst_mod_data", mod_data, 0);
      check_eq("rst_active", active, 0);
      check_eq("rst_grant", grant, 0);
      check_eq("rst_word_done", word_done, 0);
      en = 1'b1;
      req0_valid = 1'b1;
      req0_data = 16'hAAAA;
      #1;
      check_eq("rst_ready0", req0_ready, 0);
      tick(3);
      rst = 1'b1;
      push(16'hAAAA, 1'b0, 0);
      @(negedge clk);
      check_eq("t1_ready0", req0_ready, 1);
      check_eq("t1_no_ld_yet", mod_ld, 0);
      tick(1);
      req0_valid = 1'b0;
      @(negedge clk);
      check_eq("t1_ld", mod_ld, 1);
      check_eq("t1_ready0_once", req0_ready, 0);
      wait_wd(1, 80, "t1_wd_seen");
      @(negedge clk);
      check_eq("t1_active_gap1", active, 1);
      @(negedge clk);
      check_eq("t1_active_gap2", active, 1);
      @(negedge clk);
      check_eq("t1_active_fall", active, 0);

      // Contention after a reset pulse (priority back to channel 0)
      tick(1);
      rst = 1'b0;
      tick(1);
      rst = 1'b1;
      base = ld_count;
      push(16'h1234, 1'b0, 0);
      push(16'h5678, 1'b1, PERIOD);
      push(16'h1234, 1'b0, PERIOD);
      push(16'h5678, 1'b1, PERIOD);
      req0_data = 16'h1234;
      req1_data = 16'h5678;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      wait_ld(base + 4, 4 * PERIOD + 10, "t2_four_loads");
      tick(1);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      wait_idle(100, "t2_idle");

      // Single requester back-to-back on channel 1
      tick(1);
      base = ld_count;
      req1_data = 16'hC000;
      push(16'hC000, 1'b1, 0);
      req1_valid = 1'b1;
      for (int w = 0; w < 3; w++) begin
         wait_ld(base + w + 1, PERIOD + 10, "t3_load");
         tick(1);
         if (w < 2) begin
            req1_data = 16'hC000 + 16'(w + 1);
            push(req1_data, 1'b1, PERIOD);
         end else begin
            req1_valid = 1'b0;
         end
      end
      wait_idle(100, "t3_idle");

      // Enable dropped mid-word
      tick(1);
      base = ld_count;
      req0_data = 16'h9ABC;
      req0_valid = 1'b1;
      push(16'h9ABC, 1'b0, 0);
      wait_ld(base + 1, 5, "t4_load");
      tick(1);
      req0_valid = 1'b0;
      req1_data = 16'h0F0F;
      req1_valid = 1'b1;
      tick(10);
      en = 1'b0;
      wd0 = wd_count;
      ld0 = ld_count;
      wait_wd(wd0 + 1, 80, "t4_wd_with_en_low");
      wait_idle(10, "t4_idle");
      tick(5);
      check_eq("t4_no_accept_en_low", ld_count, ld0);
      push(16'h0F0F, 1'b1, 0);
      en = 1'b1;
      @(negedge clk);
      check_eq("t4_ready1_same_cycle", req1_ready, 1);
      tick(1);
      req1_valid = 1'b0;
      wait_ld(ld0 + 1, 1, "t4_load_after_en");
      wait_idle(100, "t4_idle2");

      // Reset at SEND count 20
      tick(1);
      base = ld_count;
      req0_data = 16'h5555;
      req0_valid = 1'b1;
      push(16'h5555, 1'b0, 0);
      wait_ld(base + 1, 5, "t5_load");
      tick(1);
      req0_valid = 1'b0;
      tick(20);
      wd0 = wd_count;
      rst = 1'b0;
      #1;
      check_eq("t5_rst_mod_ld", mod_ld, 0);
      check_eq("t5_rst_mod_data", mod_data, 0);
      check_eq("t5_rst_active", active, 0);
      check_eq("t5_rst_word_done", word_done, 0);
      req1_data = 16'h7777;
      req1_valid = 1'b1;
      #1;
      check_eq("t5_rst_ready1", req1_ready, 0);
      push(16'h7777, 1'b1, 0);
      tick(2);
      rst = 1'b1;
      @(negedge clk);
      check_eq("t5_ready1_after_rst", req1_ready, 1);
      check_eq("t5_no_wd_aborted", wd_count, wd0);
      ld0 = ld_count;
      tick(1);
      req1_valid = 1'b0;
      wait_ld(ld0 + 1, 1, "t5_ld_next_cycle");
      wait_idle(100, "t5_idle");
      check_eq("t5_wd_new_word", wd_count, wd0 + 1);

      // Short corner: BIT_PERIOD=1, GAP_CYCLES=0
      tick(1);
      b_d0 = 16'hBEEF;
      b_v0 = 1'b1;
      t_prev = 0;
      for (int w = 0; w < 3; w++) begin
         k = 0;
         do begin
            @(negedge clk);
            k++;
         end while (!b_ld && k < 40);
         check_eq("p_ld_seen", b_ld, 1);
         t_ld = cyc;
         check_eq("p_data", b_mdata, 16'hBEEF);
         if (w > 0) check_eq("p_period", t_ld - t_prev, 18);
         t_prev = t_ld;
         k = 0;
         do begin
            @(negedge clk);
            k++;
         end while (!b_wd && k < 40);
         check_eq("p_wd_latency", cyc - t_ld, 16);
         @(negedge clk);
         check_eq("p_idle_after_wd", b_active, 0);
         check_eq("p_ready_after_wd", b_r0, 1);
      end
      tick(1);
      b_v0 = 1'b0;
      tick(25);
      check_eq("p_idle_end", b_active, 0);

      check_eq("sb_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bpsk_tx_scheduler.md
# bpsk_tx_scheduler

Transmit scheduler in front of the BPSK modulator. Arbitrates between two word sources with round-robin priority, loads the granted 16-bit word into the modulator with a single-cycle `mod_ld` pulse, then holds off for the full on-air duration of the word plus a guard gap before accepting the next word. It replaces hand-driven `ld`/`data` sequencing and is the only block allowed to drive the modulator's load inputs.

## Interface
- `DATA_W`, 16: word width; must match the modulator data width.
- `BIT_PERIOD`, 4: clock cycles the modulator spends per data bit; must be ≥ 1.
- `GAP_CYCLES`, 2: idle guard cycles after each word; must be ≥ 0.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  scheduler enable; gates acceptance of new words only.
- `req0_valid`  in  1  channel 0 word available.
- `req0_data`  in  DATA_W  channel 0 word.
- `req0_ready`  out  1  channel 0 word accepted this cycle.
- `req1_valid`  in  1  channel 1 word available.
- `req1_data`  in  DATA_W  channel 1 word.
- `req1_ready`  out  1  channel 1 word accepted this cycle.
- `mod_ld`  out  1  one-cycle load strobe to the modulator.
- `mod_data`  out  DATA_W  word presented to the modulator; registered.
- `active`  out  1  high whenever state ≠ IDLE.
- `grant`  out  1  channel of the word most recently accepted.
- `word_done`  out  1  one-cycle pulse on the last SEND cycle.

## Operation
- States: IDLE, LOAD, SEND, GAP.
- IDLE:
  - Arbitrate when `en`=1 and at least one `reqN_valid`=1.
  - `reqN_ready` is combinational and high only for the selected channel, only in IDLE with `en`=1 and its valid high.
  - Acceptance happens on valid&ready. That cycle latches the data into `mod_data`, sets `grant`=N, and moves to LOAD.
- Round-robin: register `prio` resets to 0.
  - If only one channel is valid, it wins.
  - If both are valid, channel `prio` wins.
  - After any grant to channel N, `prio` ← 1−N.
- LOAD:
  - `mod_ld`=1 for exactly this cycle.
  - Clear the beat counter and move to SEND.
- SEND:
  - Lasts exactly DATA_W×BIT_PERIOD cycles. The counter runs 0 … DATA_W×BIT_PERIOD−1 and is $clog2(DATA_W×BIT_PERIOD) bits wide.
  - On the count of DATA_W×BIT_PERIOD−1, `word_done`=1. Go to GAP if GAP_CYCLES>0, otherwise to IDLE.
- GAP: lasts GAP_CYCLES cycles, then IDLE.
- `mod_data` holds its value from acceptance until the next acceptance. It never changes during LOAD, SEND or GAP.
- Requesters must hold valid and data stable until ready. Valid dropping before ready is not an error; nothing is accepted.
- `en` low:
  - Blocks acceptance in IDLE only.
  - A word in LOAD/SEND/GAP completes normally, including `word_done` and the gap.
  - `en` rising in IDLE with valid present accepts in that same cycle.

## Timing
- Reset values (immediate on `rst`=0, asynchronous): state IDLE, `mod_ld`=0, `mod_data`=0, `active`=0, `grant`=0, `word_done`=0, `prio`=0, counters 0.
- `reqN_ready` is 0 while `rst`=0.
- Latency:
  - Acceptance edge → `mod_ld` high on the next cycle.
  - `mod_ld` → `word_done` is DATA_W×BIT_PERIOD cycles later, on the last SEND cycle.
- Minimum word period (acceptance to acceptance) is 2 + DATA_W×BIT_PERIOD + GAP_CYCLES. With defaults this is 68 cycles.
- Reset mid-word:
  - Abort immediately: no `word_done`, and the word is lost.
  - After release, the scheduler resumes from IDLE with `prio`=0.
- Valid rising on one channel in the cycle the other is accepted: nothing extra happens; it waits for the next IDLE.

## Test plan
- Reset then single word: `rst` low 3 cycles, then `en`=1, `req0_valid`=1, `req0_data`=16'hAAAA.
  - `req0_ready` pulses once.
  - Next cycle `mod_ld`=1 and `mod_data`=16'hAAAA.
  - `word_done` comes 64 cycles after `mod_ld`.
  - `active` falls 2 cycles after `word_done`.
- Contention: both channels valid continuously, ch0=16'h1234, ch1=16'h5678.
  - Grants alternate 0,1,0,1.
  - `mod_ld` pulses are spaced exactly 68 cycles apart.
  - `mod_data` alternates 1234/5678.
- Single requester back-to-back: only ch1 valid, 3 words.
  - All 3 are granted to ch1, 68 cycles apart.
  - `prio` toggling must not stall ch1.
- `en` drop: deassert `en` 10 cycles into SEND.
  - The current word completes and `word_done` pulses.
  - No `req*_ready` while `en`=0.
  - Re-assert `en`: acceptance in that same cycle.
- Reset mid-SEND: assert `rst`=0 at SEND count 20.
  - All outputs go to 0 immediately and no `word_done` is seen.
  - After release with ch1 valid, ch1 is accepted and `mod_ld` fires 1 cycle later.
- Parameter corner: GAP_CYCLES=0, BIT_PERIOD=1.
  - `word_done` is followed directly by IDLE.
  - The period is 18 cycles.
  - The counter does not wrap early.
